inv_mod_gen: RTL and testbench

- Parametrised modular inverse: computes r = a^-1 mod m for any odd modulus m of WIDTH bits, using the binary extended Euclidean algorithm.
- Successor to the fixed secp256k1 inverter. Adds a runtime modulus, valid/ready handshakes on both sides with output backpressure, single-cycle fused iteration steps, and an explicit error status.
- Sits behind the Jacobian-to-affine converter and any other field or scalar unit that needs an inverse, e.g. mod p or mod n for secp256k1.

---
 rtl/inv_mod_gen.sv | 184 ++++++++++++++++++
 tb/tb_inv_mod_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mod_gen.sv
`default_nettype none
// ============================================================================
// Module   : inv_mod_gen
// Purpose  : Modular inverse r = a^-1 mod m for a runtime odd modulus m,
//            computed with the binary extended Euclidean algorithm, one
//            fused step per clock. Valid/ready on both sides, with output
//            backpressure and an error flag.
// Options  : INV_MOD_ITER_CNT_EN adds output iter_cnt, which holds the
//            number of RUN cycles of the last completed operation.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module inv_mod_gen #(
  parameter int WIDTH    = 256,
  parameter int MAX_ITER = 4 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef INV_MOD_ITER_CNT_EN
  ,
  output logic [$clog2(MAX_ITER+1):0] iter_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_ITER + 1) + 1;

  localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_iter_max = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_u, w_u_nxt;
  logic [WIDTH-1:0] r_v, w_v_nxt;
  logic [WIDTH-1:0] r_x1, w_x1_nxt;
  logic [WIDTH-1:0] r_x2, w_x2_nxt;
  logic [WIDTH-1:0] r_m, w_m_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_err, w_err_nxt;
  logic             w_in_bad;

  // x/2 mod md: an odd x gets md added first; the sum needs WIDTH+1 bits.
  function automatic logic [WIDTH-1:0] f_half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] md);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  // (x - y) mod md for x, y already in [0, md-1].
  function automatic logic [WIDTH-1:0] f_sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] md);
    logic [WIDTH:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + {1'b0, md} - {1'b0, y};
    return s[WIDTH-1:0];
  endfunction

  // Requests that can never have an inverse are rejected without iterating.
  assign w_in_bad = (a == '0) || (a >= m) || !m[0] || (m <= c_one);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign err       = r_err;

  // Next-state and datapath: one prioritised Euclid step per RUN cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_u_nxt      = r_u;
    w_v_nxt      = r_v;
    w_x1_nxt     = r_x1;
    w_x2_nxt     = r_x2;
    w_m_nxt      = r_m;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_m_nxt      = m;
          w_u_nxt      = a;
          w_v_nxt      = m;
          w_x1_nxt     = c_one;
          w_x2_nxt     = '0;
          w_cnt_nxt    = '0;
          w_result_nxt = '0;
          w_err_nxt    = w_in_bad;
          w_state_nxt  = w_in_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt + c_cnt_one;
        if (r_u == c_one) begin
          w_result_nxt = r_x1;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_DONE;
        end else if (r_v == c_one) begin
          w_result_nxt = r_x2;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_DONE;
        end else if ((r_u == '0) || (r_v == '0) || (r_cnt == c_iter_max)) begin
          // gcd(a, m) > 1 drives one operand to zero; the counter catches
          // anything that fails to converge.
          w_result_nxt = '0;
          w_err_nxt    = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (!r_u[0]) begin
          w_u_nxt  = r_u >> 1;
          w_x1_nxt = f_half_mod(r_x1, r_m);
        end else if (!r_v[0]) begin
          w_v_nxt  = r_v >> 1;
          w_x2_nxt = f_half_mod(r_x2, r_m);
        end else if (r_u > r_v) begin
          w_u_nxt  = r_u - r_v;
          w_x1_nxt = f_sub_mod(r_x1, r_x2, r_m);
        end else begin
          w_v_nxt  = r_v - r_u;
          w_x2_nxt = f_sub_mod(r_x2, r_x1, r_m);
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_u      <= '0;
      r_v      <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_u      <= w_u_nxt;
      r_v      <= w_v_nxt;
      r_x1     <= w_x1_nxt;
      r_x2     <= w_x2_nxt;
      r_m      <= w_m_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

`ifdef INV_MOD_ITER_CNT_EN
  logic [CNT_W-1:0] r_iter_cnt;

  assign iter_cnt = r_iter_cnt;

  // Capture the RUN-cycle count on entry to DONE (zero for rejected input).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter_cnt <= '0;
    end else if ((r_state != S_DONE) && (w_state_nxt == S_DONE)) begin
      r_iter_cnt <= (r_state == S_RUN) ? (r_cnt + c_cnt_one) : '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_mod_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_mod_gen
// Purpose  : Randomised self-checking bench for inv_mod_gen with a 256-bit
//            instance (secp256k1 p and n) and an 8-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_mod_gen;

  localparam logic [255:0] c_p =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] c_n =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [255:0] c_p_half =
    256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;

  logic clk = 1'b0;
  logic rst_n;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
  logic [255:0] w_a, w_m, w_result;
  logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_err;
  logic [7:0]   n_a, n_m, n_result;
`ifdef INV_MOD_ITER_CNT_EN
  logic [11:0]  w_iter_cnt;
  logic [7:0]   n_iter_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inv_mod_gen #(.WIDTH(256)) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a         (w_a),
    .m         (w_m),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .result    (w_result),
    .err       (w_err)
`ifdef INV_MOD_ITER_CNT_EN
    ,
    .iter_cnt  (w_iter_cnt)
`endif
  );

  inv_mod_gen #(.WIDTH(8), .MAX_ITER(64)) u_dut_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .a         (n_a),
    .m         (n_m),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .result    (n_result),
    .err       (n_err)
`ifdef INV_MOD_ITER_CNT_EN
    ,
    .iter_cnt  (n_iter_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [255:0] obs,
                          input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: textbook extended Euclid with division, coefficients mod m.
  task automatic ref_inv(input logic [255:0] ra, input logic [255:0] rm,
                         output logic [255:0] rres, output logic rerr);
    logic [511:0] r0, r1, t0, t1, q, tmp, mm;
    rres = '0;
    rerr = 1'b1;
    if (ra == 0 || ra >= rm || rm[0] == 1'b0 || rm <= 1) return;
    mm = {256'd0, rm};
    r0 = mm;
    r1 = {256'd0, ra};
    t0 = '0;
    t1 = 512'd1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = (t0 + mm - (q * t1) % mm) % mm;
      t0  = t1;
      t1  = tmp;
    end
    if (r0 == 512'd1) begin
      rres = t0[255:0];
      rerr = 1'b0;
    end
  endtask

  // One request on the 256-bit instance; tcyc = edges from acceptance to out_valid.
  task automatic run_w(input logic [255:0] ta, input logic [255:0] tm,
                       output logic [255:0] tres, output logic terr,
                       output int tcyc);
    int guard;
    guard = 0;
    while (!w_in_ready && guard < 100) begin @(negedge clk); guard++; end
    w_in_valid = 1'b1;
    w_a = ta;
    w_m = tm;
    @(negedge clk);
    w_in_valid = 1'b0;
    w_a = rand256();
    w_m = rand256();
    tcyc = 1;
    while (!w_out_valid && tcyc < 2000) begin @(negedge clk); tcyc++; end
    if (!w_out_valid) check_eq("w_timeout", 256'd0, 256'd1);
    tres = w_result;
    terr = w_err;
`ifdef INV_MOD_ITER_CNT_EN
    if (w_out_valid) check_eq("w_iter_cnt", 256'(w_iter_cnt), 256'(tcyc - 1));
`endif
    @(negedge clk);
  endtask

  task automatic run_n(input logic [255:0] ta, input logic [255:0] tm,
                       output logic [255:0] tres, output logic terr,
                       output int tcyc);
    int guard;
    guard = 0;
    while (!n_in_ready && guard < 100) begin @(negedge clk); guard++; end
    n_in_valid = 1'b1;
    n_a = ta[7:0];
    n_m = tm[7:0];
    @(negedge clk);
    n_in_valid = 1'b0;
    n_a = 8'($urandom());
    n_m = 8'($urandom());
    tcyc = 1;
    while (!n_out_valid && tcyc < 200) begin @(negedge clk); tcyc++; end
    if (!n_out_valid) check_eq("n_timeout", 256'd0, 256'd1);
    tres = 256'(n_result);
    terr = n_err;
`ifdef INV_MOD_ITER_CNT_EN
    if (n_out_valid) check_eq("n_iter_cnt", 256'(n_iter_cnt), 256'(tcyc - 1));
`endif
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ta, tm, res, eres, bres;
    logic [511:0] prod;
    logic         e, eerr, berr;
    int           cyc, seen;

    rst_n = 1'b0;
    w_in_valid = 1'b0; w_a = '0; w_m = '0; w_out_ready = 1'b1;
    n_in_valid = 1'b0; n_a = '0; n_m = '0; n_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 256'(w_in_ready), 256'd1);
    check_eq("rst_out_valid", 256'(w_out_valid), 256'd0);
    check_eq("rst_result", w_result, 256'd0);
    check_eq("rst_err", 256'(w_err), 256'd0);
    check_eq("rst_n_in_ready", 256'(n_in_ready), 256'd1);
    check_eq("rst_n_out_valid", 256'(n_out_valid), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // a = 1: a single RUN cycle
    run_w(256'd1, c_p, res, e, cyc);
    check_eq("p_a1_res", res, 256'd1);
    check_eq("p_a1_err", 256'(e), 256'd0);
    check_eq("p_a1_lat", 256'(cyc), 256'd2);

    run_w(256'd2, c_p, res, e, cyc);
    check_eq("p_a2_res", res, c_p_half);
    check_eq("p_a2_err", 256'(e), 256'd0);

    // random operands mod p and mod n
    for (int i = 0; i < 30; i++) begin
      tm = (i % 5 == 4) ? c_n : c_p;
      ta = rand256() % tm;
      if (ta == 0) ta = 256'd7;
      ref_inv(ta, tm, eres, eerr);
      run_w(ta, tm, res, e, cyc);
      check_eq("rnd256_res", res, eres);
      check_eq("rnd256_err", 256'(e), 256'(eerr));
      prod = ({256'd0, ta} * {256'd0, res}) % {256'd0, tm};
      check_eq("rnd256_prod", prod[255:0], 256'd1);
    end

    // invalid 256-bit request: no RUN cycles
    run_w(256'd0, c_p, res, e, cyc);
    check_eq("w_a0_err", 256'(e), 256'd1);
    check_eq("w_a0_lat", 256'(cyc), 256'd1);

    // 8-bit fixed cases
    run_n(256'd3, 256'd251, res, e, cyc);
    check_eq("n_251_3_res", res, 256'd84);
    check_eq("n_251_3_err", 256'(e), 256'd0);
    run_n(256'd6, 256'd15, res, e, cyc);
    check_eq("n_15_6_res", res, 256'd0);
    check_eq("n_15_6_err", 256'(e), 256'd1);

    // invalid requests: a = 0, a = m, even m
    run_n(256'd0, 256'd251, res, e, cyc);
    check_eq("n_a0_err", 256'(e), 256'd1);
    check_eq("n_a0_res", res, 256'd0);
    check_eq("n_a0_lat", 256'(cyc), 256'd1);
    run_n(256'd251, 256'd251, res, e, cyc);
    check_eq("n_aeqm_err", 256'(e), 256'd1);
    check_eq("n_aeqm_lat", 256'(cyc), 256'd1);
    run_n(256'd5, 256'd16, res, e, cyc);
    check_eq("n_meven_err", 256'(e), 256'd1);
    check_eq("n_meven_lat", 256'(cyc), 256'd1);

    // random 8-bit operands and moduli, including invalid ones
    for (int i = 0; i < 200; i++) begin
      tm = 256'($urandom_range(255, 0) | 1);
      if ($urandom_range(7, 0) == 0) tm = 256'($urandom_range(255, 0));
      ta = 256'($urandom_range(255, 0));
      ref_inv(ta, tm, eres, eerr);
      run_n(ta, tm, res, e, cyc);
      check_eq("rnd8_res", res, eres);
      check_eq("rnd8_err", 256'(e), 256'(eerr));
    end

    // backpressure: hold out_ready low for 10 cycles after out_valid
    n_out_ready = 1'b0;
    ref_inv(256'd7, 256'd251, eres, eerr);
    n_in_valid = 1'b1; n_a = 8'd7; n_m = 8'd251;
    @(negedge clk);
    n_in_valid = 1'b0;
    cyc = 1;
    while (!n_out_valid && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq("bp_valid", 256'(n_out_valid), 256'd1);
    bres = 256'(n_result);
    berr = n_err;
    check_eq("bp_res", bres, eres);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", 256'(n_out_valid), 256'd1);
      check_eq("bp_hold_res", 256'(n_result), bres);
      check_eq("bp_hold_err", 256'(n_err), 256'(berr));
      check_eq("bp_hold_ready", 256'(n_in_ready), 256'd0);
    end
    n_out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_valid", 256'(n_out_valid), 256'd0);
    check_eq("bp_rel_ready", 256'(n_in_ready), 256'd1);

    // reset in the middle of a 256-bit operation
    w_in_valid = 1'b1; w_a = rand256() % c_p; w_m = c_p;
    if (w_a == 0) w_a = 256'd3;
    @(negedge clk);
    w_in_valid = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("mid_busy", 256'(w_in_ready), 256'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 256'(w_in_ready), 256'd1);
    check_eq("mid_rst_out_valid", 256'(w_out_valid), 256'd0);
    check_eq("mid_rst_result", w_result, 256'd0);
    check_eq("mid_rst_err", 256'(w_err), 256'd0);
`ifdef INV_MOD_ITER_CNT_EN
    check_eq("mid_rst_iter", 256'(w_iter_cnt), 256'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (w_out_valid) seen++;
    end
    check_eq("mid_no_out", 256'(seen), 256'd0);
    ta = rand256() % c_p;
    if (ta == 0) ta = 256'd5;
    ref_inv(ta, c_p, eres, eerr);
    run_w(ta, c_p, res, e, cyc);
    check_eq("post_rst_res", res, eres);
    check_eq("post_rst_err", 256'(e), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
